// File: rtl/keymem_arbiter_pkg.sv
// keymem_arbiter_pkg: shared FSM encoding and widths for the keymem arbiter.
package keymem_arbiter_pkg;

    localparam int unsigned KEY_WIDTH     = 256;
    localparam int unsigned KEY_ID_WIDTH  = 32;
    localparam int unsigned TMO_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/keymem_rr_arbiter.sv
// keymem_rr_arbiter: combinational round-robin select among unmasked requests,
// searching upward from the path after last_grant_i.
module keymem_rr_arbiter #(
    parameter int unsigned NUM_PATHS = 4,
    parameter int unsigned IDX_W     = $clog2(NUM_PATHS)
) (
    input  logic [NUM_PATHS-1:0] req_i,
    input  logic [NUM_PATHS-1:0] mask_i,
    input  logic [IDX_W-1:0]     last_grant_i,
    output logic [IDX_W-1:0]     winner_o,
    output logic                 valid_o
);

    logic [NUM_PATHS-1:0] eligible;
    int unsigned          cand;
    logic [IDX_W-1:0]     cand_idx;

    // Walk offsets from farthest to nearest so the nearest eligible path wins.
    always_comb begin
        eligible = req_i & ~mask_i;
        winner_o = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = NUM_PATHS; k > 0; k--) begin
            cand     = (32'(last_grant_i) + k) % NUM_PATHS;
            cand_idx = IDX_W'(cand);
            if (eligible[cand_idx]) begin
                winner_o = cand_idx;
            end
        end
        valid_o = |eligible;
    end

endmodule

// File: rtl/keymem_arbiter.sv
// keymem_arbiter: shares one keymem between NUM_PATHS network paths with
// round-robin arbitration, one transaction in flight at a time.
// Optional feature: define KEYMEM_ARBITER_TIMEOUT_EN to bound the keymem ack
// wait to TIMEOUT_CYCLES cycles and report expiry on path_key_err.
module keymem_arbiter
    import keymem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PATHS      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                           clk156,
    input  logic                           areset_n,
    input  logic [NUM_PATHS-1:0]              path_key_req,
    input  logic [NUM_PATHS*KEY_ID_WIDTH-1:0] path_key_id,
    output logic [NUM_PATHS-1:0]              path_key_ack,
    output logic [KEY_WIDTH-1:0]              path_key,
    output logic                           path_key_err,
    output logic                           key_req,
    output logic [KEY_ID_WIDTH-1:0]        key_id,
    input  logic                           key_ack,
    input  logic [KEY_WIDTH-1:0]           key
);

    localparam int unsigned IDX_W = $clog2(NUM_PATHS);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        grant_q, grant_d;
    logic [IDX_W-1:0]        last_grant_q, last_grant_d;
    logic [NUM_PATHS-1:0]    mask_q, mask_d;
    logic                    key_req_q, key_req_d;
    logic [KEY_ID_WIDTH-1:0] key_id_q, key_id_d;
    logic [KEY_WIDTH-1:0]    key_q, key_d;

    logic [IDX_W-1:0]        win_idx;
    logic                    win_valid;
    logic [KEY_ID_WIDTH-1:0] win_id;
    logic [NUM_PATHS-1:0]    grant_onehot;

`ifdef KEYMEM_ARBITER_TIMEOUT_EN
    localparam logic [TMO_CNT_WIDTH-1:0] TMO_LIMIT = TMO_CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    logic                     err_q, err_d;
    logic [TMO_CNT_WIDTH-1:0] cnt_q, cnt_d;
`else
    // Timeout is compiled out; the parameter stays so instantiations are unchanged.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

    keymem_rr_arbiter #(
        .NUM_PATHS (NUM_PATHS),
        .IDX_W     (IDX_W)
    ) u_rr (
        .req_i        (path_key_req),
        .mask_i       (mask_q),
        .last_grant_i (last_grant_q),
        .winner_o     (win_idx),
        .valid_o      (win_valid)
    );

    // Pick the winner's id and decode the current grant to one-hot.
    always_comb begin
        win_id       = '0;
        grant_onehot = '0;
        for (int unsigned i = 0; i < NUM_PATHS; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_id = path_key_id[i*KEY_ID_WIDTH +: KEY_ID_WIDTH];
            end
            grant_onehot[i] = (grant_q == IDX_W'(i));
        end
    end

    // Next-state logic for the IDLE -> ISSUE -> WAIT -> DONE transaction.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        mask_d       = '0;
        key_req_d    = key_req_q;
        key_id_d     = key_id_q;
        key_d        = key_q;
`ifdef KEYMEM_ARBITER_TIMEOUT_EN
        err_d        = err_q;
        cnt_d        = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    grant_d  = win_idx;
                    key_id_d = win_id;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                key_req_d = 1'b1;
`ifdef KEYMEM_ARBITER_TIMEOUT_EN
                err_d     = 1'b0;
                cnt_d     = '0;
`endif
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (key_ack) begin
                    key_d     = key;
                    key_req_d = 1'b0;
                    state_d   = ST_DONE;
                end
`ifdef KEYMEM_ARBITER_TIMEOUT_EN
                else if (cnt_q == TMO_LIMIT) begin
                    key_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                last_grant_d = grant_q;
                // Mask the path just served for one IDLE cycle so its trailing req is ignored.
                mask_d       = grant_onehot;
                key_d        = '0;
`ifdef KEYMEM_ARBITER_TIMEOUT_EN
                err_d        = 1'b0;
`endif
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk156 or negedge areset_n) begin
        if (!areset_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_PATHS - 1);
            mask_q       <= '0;
            key_req_q    <= 1'b0;
            key_id_q     <= '0;
            key_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            mask_q       <= mask_d;
            key_req_q    <= key_req_d;
            key_id_q     <= key_id_d;
            key_q        <= key_d;
        end
    end

`ifdef KEYMEM_ARBITER_TIMEOUT_EN
    // Timeout counter and error flag.
    always_ff @(posedge clk156 or negedge areset_n) begin
        if (!areset_n) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign path_key_err = (state_q == ST_DONE) ? err_q : 1'b0;
`else
    assign path_key_err = 1'b0;
`endif

    assign path_key_ack = (state_q == ST_DONE) ? grant_onehot : '0;
    assign path_key     = (state_q == ST_DONE) ? key_q : '0;
    assign key_req      = key_req_q;
    assign key_id       = key_id_q;

endmodule

// File: tb/tb_keymem_arbiter.sv
// tb_keymem_arbiter: directed bench for keymem_arbiter (NUM_PATHS=4, TIMEOUT_CYCLES=8).
module tb_keymem_arbiter;

    localparam int unsigned NP = 4;

    logic          clk156 = 1'b0;
    logic          areset_n;
    logic [NP-1:0] path_key_req;
    logic [NP*32-1:0] path_key_id;
    logic [NP-1:0] path_key_ack;
    logic [255:0]  path_key;
    logic          path_key_err;
    logic          key_req;
    logic [31:0]   key_id;
    logic          key_ack;
    logic [255:0]  key;

    int vectors     = 0;
    int miscompares = 0;

    keymem_arbiter #(
        .NUM_PATHS      (NP),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk156       (clk156),
        .areset_n     (areset_n),
        .path_key_req (path_key_req),
        .path_key_id  (path_key_id),
        .path_key_ack (path_key_ack),
        .path_key     (path_key),
        .path_key_err (path_key_err),
        .key_req      (key_req),
        .key_id       (key_id),
        .key_ack      (key_ack),
        .key          (key)
    );

    always #5 clk156 = ~clk156;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for key_req, acks after 'lag' cycles of key_req, returns the DONE-cycle outputs.
    task automatic keymem_respond(input logic [255:0] k, input int lag,
                                  output logic [3:0] ack_seen, output logic [31:0] id_seen,
                                  output logic [255:0] key_seen, output logic err_seen);
        int n = 0;
        while (key_req !== 1'b1 && n < 20) begin
            @(negedge clk156);
            n++;
        end
        check("key_req_wait", 256'(key_req), 256'(1));
        id_seen = key_id;
        repeat (lag - 1) @(negedge clk156);
        key_ack = 1'b1;
        key     = k;
        @(negedge clk156);
        key_ack  = 1'b0;
        key      = '0;
        ack_seen = path_key_ack;
        key_seen = path_key;
        err_seen = path_key_err;
    endtask

    initial begin
        logic [3:0]   ack_seen;
        logic [31:0]  id_seen;
        logic [255:0] key_seen;
        logic         err_seen;
        logic [255:0] kp;
        logic [255:0] last_key;
        logic [255:0] key_a5;
        logic         real_ack_prev;
        int           lag;
        logic [3:0]   exp_ack [4];
        logic [31:0]  exp_id [4];

        key_a5  = {32{8'hA5}};
        exp_ack = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
        exp_id  = '{32'hA0, 32'hA1, 32'hA3, 32'hA0};

        // Reset state
        areset_n     = 1'b0;
        path_key_req = '0;
        path_key_id  = '0;
        key_ack      = 1'b0;
        key          = '0;
        repeat (2) @(negedge clk156);
        check("rst_key_req", 256'(key_req), 256'(0));
        check("rst_key_id", 256'(key_id), 256'(0));
        check("rst_path_ack", 256'(path_key_ack), 256'(0));
        check("rst_path_key", path_key, '0);
        check("rst_path_err", 256'(path_key_err), 256'(0));
        areset_n = 1'b1;

        // Contention: paths 0,1,3 hold requests -> grants 0,1,3,0
        path_key_id  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        path_key_req = 4'b1011;
        for (int t = 0; t < 4; t++) begin
            kp = {8{32'hC0DE_0000 + 32'(t)}};
            keymem_respond(kp, 2, ack_seen, id_seen, key_seen, err_seen);
            check($sformatf("rr%0d_ack", t), 256'(ack_seen), 256'(exp_ack[t]));
            check($sformatf("rr%0d_key_id", t), 256'(id_seen), 256'(exp_id[t]));
            check($sformatf("rr%0d_key", t), key_seen, kp);
            path_key_req = path_key_req & ~ack_seen;
            @(negedge clk156);
            if (t < 3) path_key_req = path_key_req | ack_seen;
            else path_key_req = '0;
        end

        // Single request from path 2, keymem acks 3 cycles after key_req
        path_key_id        = '0;
        path_key_id[95:64] = 32'h0000_0011;
        path_key_req       = 4'b0100;
        @(negedge clk156);
        check("lat1_key_req", 256'(key_req), 256'(0));
        @(negedge clk156);
        check("lat2_key_req", 256'(key_req), 256'(1));
        check("single_key_id", 256'(key_id), 256'(32'h11));
        repeat (2) @(negedge clk156);
        check("wait_hold_key_req", 256'(key_req), 256'(1));
        check("wait_hold_key_id", 256'(key_id), 256'(32'h11));
        key_ack = 1'b1;
        key     = key_a5;
        @(negedge clk156);
        key_ack = 1'b0;
        key     = '0;
        check("single_ack", 256'(path_key_ack), 256'(4'b0100));
        check("single_key", path_key, key_a5);
        check("single_err", 256'(path_key_err), 256'(0));
        check("single_key_req_drop", 256'(key_req), 256'(0));
        @(negedge clk156);
        check("after_done_ack", 256'(path_key_ack), 256'(0));
        check("after_done_key", path_key, '0);
        @(negedge clk156);
        path_key_req = '0;
        @(negedge clk156);
        check("trailing_req_masked", 256'(key_req), 256'(0));

        // Key isolation: 100 cycles of traffic with spurious key_ack outside WAIT
        path_key_id   = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        path_key_req  = 4'b1010;
        real_ack_prev = 1'b0;
        lag           = 0;
        last_key      = '0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk156);
            check("iso_key_gate", 256'((path_key != '0) && (path_key_ack == '0)), 256'(0));
            check("iso_ack_source", 256'(|path_key_ack), 256'(real_ack_prev));
            if (|path_key_ack) check("iso_key_value", path_key, last_key);
            if (|path_key_ack) path_key_req = path_key_req & ~path_key_ack;
            else path_key_req = 4'b1010;
            real_ack_prev = 1'b0;
            if (key_req) begin
                if (lag == 2) begin
                    key_ack       = 1'b1;
                    key           = {8{32'hF00D_0000 + 32'(c)}};
                    last_key      = key;
                    real_ack_prev = 1'b1;
                    lag           = 0;
                end else begin
                    key_ack = 1'b0;
                    key     = '0;
                    lag++;
                end
            end else begin
                lag     = 0;
                key_ack = (c % 3 == 0);
                key     = key_ack ? '1 : '0;
            end
        end
        path_key_req = '0;
        key          = '0;
        repeat (20) begin
            @(negedge clk156);
            key_ack = key_req;
        end
        key_ack = 1'b0;
        @(negedge clk156);
        check("drain_idle", 256'(key_req), 256'(0));

        // Timeout behaviour
        path_key_id        = '0;
        path_key_id[63:32] = 32'h77;
        path_key_req       = 4'b0010;
        repeat (2) @(negedge clk156);
        check("tmo_key_req_up", 256'(key_req), 256'(1));
`ifdef KEYMEM_ARBITER_TIMEOUT_EN
        repeat (7) @(negedge clk156);
        check("tmo_last_wait_key_req", 256'(key_req), 256'(1));
        @(negedge clk156);
        check("tmo_key_req_drop", 256'(key_req), 256'(0));
        check("tmo_ack", 256'(path_key_ack), 256'(4'b0010));
        check("tmo_err", 256'(path_key_err), 256'(1));
        check("tmo_key", path_key, '0);
        path_key_req = '0;
        @(negedge clk156);
        check("tmo_ack_clear", 256'(path_key_ack), 256'(0));
        path_key_id[127:96] = 32'h99;
        path_key_req        = 4'b1000;
        repeat (2) @(negedge clk156);
        check("pre_rst_key_req", 256'(key_req), 256'(1));
`else
        repeat (50) @(negedge clk156);
        check("no_tmo_key_req", 256'(key_req), 256'(1));
        check("no_tmo_ack", 256'(path_key_ack), 256'(0));
        check("no_tmo_err", 256'(path_key_err), 256'(0));
`endif

        // Reset in the middle of WAIT
        @(negedge clk156);
        #2;
        areset_n     = 1'b0;
        path_key_id  = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        path_key_req = 4'b1101;
        #1;
        check("async_rst_key_req", 256'(key_req), 256'(0));
        check("async_rst_key_id", 256'(key_id), 256'(0));
        @(negedge clk156);
        areset_n = 1'b1;
        @(negedge clk156);
        check("post_rst_issue", 256'(key_req), 256'(0));
        @(negedge clk156);
        check("post_rst_key_req", 256'(key_req), 256'(1));
        check("post_rst_key_id", 256'(key_id), 256'(32'hD0));
        kp = {8{32'h5A5A_0001}};
        keymem_respond(kp, 1, ack_seen, id_seen, key_seen, err_seen);
        check("post_rst_ack", 256'(ack_seen), 256'(4'b0001));
        check("post_rst_key", key_seen, kp);
        path_key_req = '0;
        repeat (3) @(negedge clk156);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
